audio_mixer: RTL

- Mixes the card audio sources into one unsigned 16-bit stereo pair at the HDMI audio sample rate.
- Sources: SuperSprite PSG, Mockingboard L/R, and the Apple speaker bit.
- Sits directly upstream of audio_out and replaces the ad-hoc combinational sum at its core_l/core_r inputs.
- Adds per-source gain, saturation, a fractional sample-tick generator, and speaker DC-decay so an idle speaker held high does not leave a DC offset.

---
 rtl/audio_mixer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: gain/saturating stereo mixer with fractional sample ticks and speaker DC decay; `define AUDIO_MIXER_CLIP_EN for sticky clip flags
module audio_mixer #(
  parameter int unsigned CLOCK_SPEED_HZ = 27_000_000,
  parameter int unsigned SAMPLE_RATE = 44100,
  parameter logic [15:0] SPEAKER_AMP = 16'h2000,
  parameter int unsigned SPEAKER_IDLE_SAMPLES = 2205,
  parameter logic [15:0] SPEAKER_DECAY_STEP = 16'h0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic        speaker_en_i,
  input  logic [3:0]  ssp_gain_i,
  input  logic [3:0]  mb_gain_i,
  input  logic [3:0]  spk_gain_i,
  input  logic        mute_i,
  input  logic        clip_clr_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        sample_strobe_o,
  output logic        clip_l_o,
  output logic        clip_r_o
);
  localparam int IW = $clog2(SPEAKER_IDLE_SAMPLES + 1);

  logic [31:0] acc_q, acc_d;
  logic [32:0] acc_sum;
  logic        tick;
  logic        sync1_q, sync2_q, prev_q, spk_edge, spk_sat;
  logic [15:0] amp_q, amp_d, spk_term;
  logic [IW-1:0] idle_q, idle_d;
  logic        v1_q, mute1_q;
  logic [15:0] ssp1_q, mbl1_q, mbr1_q, spk1_q;
  logic [3:0]  gs1_q, gm1_q, gk1_q;
  logic        v2_q, mute2_q;
  logic [16:0] ssp2_q, mbl2_q, mbr2_q, spk2_q;
  logic [16:0] ssp2_d, mbl2_d, mbr2_d, spk2_d;
  logic [18:0] sum_l, sum_r;
  logic        sat_l, sat_r, clip_l_new, clip_r_new;
  logic [15:0] audio_l_q, audio_r_q, audio_l_d, audio_r_d;
  logic        strobe_q;

  // Phase accumulator wrap and speaker amplitude/idle bookkeeping
  always_comb begin
    acc_sum = {1'b0, acc_q} + 33'(SAMPLE_RATE);
    tick = acc_sum >= 33'(CLOCK_SPEED_HZ);
    acc_d = tick ? 32'(acc_sum - 33'(CLOCK_SPEED_HZ)) : acc_sum[31:0];
    spk_edge = sync2_q ^ prev_q;
    spk_sat = idle_q >= IW'(SPEAKER_IDLE_SAMPLES - 1);
    idle_d = spk_edge ? '0 : !tick ? idle_q : spk_sat ? IW'(SPEAKER_IDLE_SAMPLES) : idle_q + IW'(1);
    amp_d = spk_edge ? SPEAKER_AMP : !(tick && spk_sat) ? amp_q :
            amp_q >= SPEAKER_DECAY_STEP ? amp_q - SPEAKER_DECAY_STEP : '0;
    spk_term = (sync2_q && speaker_en_i) ? amp_q : '0;
  end

  // Tick generator, speaker synchroniser and decay state
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q <= 1'b0;
      amp_q <= SPEAKER_AMP;
      idle_q <= '0;
    end else begin
      acc_q <= acc_d;
      sync1_q <= speaker_i;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      amp_q <= amp_d;
      idle_q <= idle_d;
    end
  end

  // Stage 1: capture sources, gains and mute on the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      mute1_q <= 1'b0;
      ssp1_q <= '0;
      mbl1_q <= '0;
      mbr1_q <= '0;
      spk1_q <= '0;
      gs1_q <= '0;
      gm1_q <= '0;
      gk1_q <= '0;
    end else begin
      v1_q <= tick;
      if (tick) begin
        mute1_q <= mute_i;
        ssp1_q <= ssp_audio_i;
        mbl1_q <= {1'b0, mb_audio_l_i, 5'b0};
        mbr1_q <= {1'b0, mb_audio_r_i, 5'b0};
        spk1_q <= spk_term;
        gs1_q <= ssp_gain_i;
        gm1_q <= mb_gain_i;
        gk1_q <= spk_gain_i;
      end
    end
  end

  // Gain scaling (8 = unity) and per-channel saturating sum
  always_comb begin
    ssp2_d = 17'((20'(ssp1_q) * 20'(gs1_q)) >> 3);
    mbl2_d = 17'((20'(mbl1_q) * 20'(gm1_q)) >> 3);
    mbr2_d = 17'((20'(mbr1_q) * 20'(gm1_q)) >> 3);
    spk2_d = 17'((20'(spk1_q) * 20'(gk1_q)) >> 3);
    sum_l = 19'(ssp2_q) + 19'(mbl2_q) + 19'(spk2_q);
    sum_r = 19'(ssp2_q) + 19'(mbr2_q) + 19'(spk2_q);
    sat_l = |sum_l[18:16];
    sat_r = |sum_r[18:16];
    audio_l_d = mute2_q ? '0 : sat_l ? 16'hFFFF : sum_l[15:0];
    audio_r_d = mute2_q ? '0 : sat_r ? 16'hFFFF : sum_r[15:0];
    clip_l_new = v2_q && !mute2_q && sat_l;
    clip_r_new = v2_q && !mute2_q && sat_r;
  end

  // Stage 2: register scaled terms
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q <= 1'b0;
      mute2_q <= 1'b0;
      ssp2_q <= '0;
      mbl2_q <= '0;
      mbr2_q <= '0;
      spk2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        mute2_q <= mute1_q;
        ssp2_q <= ssp2_d;
        mbl2_q <= mbl2_d;
        mbr2_q <= mbr2_d;
        spk2_q <= spk2_d;
      end
    end
  end

  // Stage 3: outputs and strobe update together, holding between samples
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else begin
      strobe_q <= v2_q;
      if (v2_q) begin
        audio_l_q <= audio_l_d;
        audio_r_q <= audio_r_d;
      end
    end
  end

  assign audio_l_o = audio_l_q;
  assign audio_r_o = audio_r_q;
  assign sample_strobe_o = strobe_q;

`ifdef AUDIO_MIXER_CLIP_EN
  logic clip_l_q, clip_r_q;

  // Sticky clip flags; a new clip wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
    end else begin
      clip_l_q <= (clip_l_q && !clip_clr_i) || clip_l_new;
      clip_r_q <= (clip_r_q && !clip_clr_i) || clip_r_new;
    end
  end

  assign clip_l_o = clip_l_q;
  assign clip_r_o = clip_r_q;
`else
  logic unused_clip;
  assign unused_clip = ^{clip_clr_i, clip_l_new, clip_r_new};
  assign clip_l_o = 1'b0;
  assign clip_r_o = 1'b0;
`endif
endmodule
